mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers, sitting beside the ULA in the execute path.
- It consumes the two register-file read operands (ReadData1, ReadData2) and produces HI/LO for MFHI/MFLO.
- It raises busy so the datapath can stall PC update and register write-back while an operation is in flight.
- Implements the MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO semantics.

---
 rtl/mult_div_unit_pkg.sv | 33 +++
 rtl/mult_div_unit_magnitude.sv | 21 ++
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and
// FSM state encoding.
package mult_div_unit_pkg;

  // Operation codes carried on the op port.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Ops that take the 32-cycle iterative path.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_magnitude.sv
// mdu_magnitude: combinational magnitude / conditional negation.
//   val       : input value
//   is_signed : treat val as two's complement
//   flip      : extra negation request, used for the final sign fix-up
//   mag       : |val| when flip=0; negated once more when flip=1
//   sign      : sign bit of val (0 when unsigned)
module mdu_magnitude #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         is_signed,
  input  logic         flip,
  output logic [W-1:0] mag,
  output logic         sign
);

  assign sign = is_signed & val[W-1];
  // Most-negative value maps to itself, which is exactly the unsigned magnitude.
  assign mag  = (sign ^ flip) ? (~val + 1'b1) : val;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit with HI/LO registers.
//   clock, reset (sync, active low)
//   start, op, a (rs), b (rt) : one-cycle request
//   busy        : operation in flight (RUN/FIX)
//   done        : one-cycle completion pulse
//   div_by_zero : valid with done; divisor was zero
//   hi, lo      : HI/LO architectural registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;        // {hi half, lo half} working register
  logic [WIDTH-1:0]   dvsr;       // multiplicand or divisor magnitude
  logic               mul_r, neg_res, neg_rem, dbz_r;

  logic               accept, div_zero, go_run, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_sgn, b_sgn;

  mdu_magnitude #(.W(WIDTH)) u_mag_a (
    .val(a), .is_signed(is_signed_op(op)), .flip(1'b0), .mag(a_mag), .sign(a_sgn));
  mdu_magnitude #(.W(WIDTH)) u_mag_b (
    .val(b), .is_signed(is_signed_op(op)), .flip(1'b0), .mag(b_mag), .sign(b_sgn));

  assign accept   = start & ((state == IDLE) | (state == DONE));
  assign div_zero = accept & is_div_op(op) & (b == '0);
  assign go_run   = accept & is_iter_op(op) & ~div_zero;
  assign last     = &cnt;

  // One iteration step for each algorithm.
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, dvsr};
    // Restoring divide: keep the subtraction only when it did not borrow.
    div_nxt = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up reuses the magnitude block's negator.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               prod_sgn_unused, quo_sgn_unused, rem_sgn_unused;

  mdu_magnitude #(.W(2*WIDTH)) u_fix_prod (
    .val(acc), .is_signed(1'b0), .flip(neg_res), .mag(prod_fix), .sign(prod_sgn_unused));
  mdu_magnitude #(.W(WIDTH)) u_fix_quo (
    .val(acc[WIDTH-1:0]), .is_signed(1'b0), .flip(neg_res), .mag(quo_fix), .sign(quo_sgn_unused));
  mdu_magnitude #(.W(WIDTH)) u_fix_rem (
    .val(acc[2*WIDTH-1:WIDTH]), .is_signed(1'b0), .flip(neg_rem), .mag(rem_fix),
    .sign(rem_sgn_unused));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and outputs.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done        = 1'b1;
          div_by_zero = dbz_r;
          state_nxt   = IDLE;
        end
        if (div_zero)    state_nxt = DONE;
        else if (go_run) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration datapath.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc     <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      mul_r   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      dbz_r <= div_zero;
      if (go_run) begin
        acc     <= {{WIDTH{1'b0}}, a_mag};
        dvsr    <= b_mag;
        cnt     <= '0;
        mul_r   <= ~is_div_op(op);
        neg_res <= a_sgn ^ b_sgn;
        neg_rem <= a_sgn;    // remainder follows the dividend
      end else if (state == RUN) begin
        acc <= mul_r ? mul_nxt : div_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // HI/LO: written only by moves, at FIX exit, or by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && op == MDU_MTHI) begin
      hi <= a;
    end else if (accept && op == MDU_MTLO) begin
      lo <= a;
    end else if (state == FIX) begin
      if (mul_r) begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end else begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clock = ~clock;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic dz);
    longint      sx, sy, p;
    logic [63:0] up;
    dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; {m_hi, m_lo} = p; end
      3'd1: begin up = {32'b0, x} * {32'b0, y}; {m_hi, m_lo} = up; end
      3'd2: if (y == 0) dz = 1'b1;
            else begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
      3'd3: if (y == 0) dz = 1'b1;
            else begin m_lo = x / y; m_hi = x % y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one request from the posedge+1 phase and follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic dz;
    int   n, nb, exp_lat;
    model(o, x, y, dz);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (o > 3'd3) begin
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
      return;
    end
    n = 0; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(posedge clock); #1;
      n++;
    end
    exp_lat = dz ? 0 : 33;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busycyc"}, nb, exp_lat);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_dbz"}, div_by_zero, dz);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic        dz;
    logic [31:0] prev_hi, prev_lo;
    int          n, pulses;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_const", lo, 32'h0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    run_op("mthi", 3'd4, 32'h1234_5678, 32'h0);
    run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'h0);
    run_op("divu_zero", 3'd3, 32'd100, 32'h0);
    chk("divu_zero_hi_const", hi, 32'h1234_5678);
    run_op("undef6", 3'd6, 32'hDEAD_BEEF, 32'h1);
    run_op("undef7", 3'd7, 32'hDEAD_BEEF, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      run_op("rnd", o, pick(), pick());
    end

    // Start while busy is ignored; HI/LO hold mid-operation.
    @(posedge clock); #1;
    prev_hi = m_hi; prev_lo = m_lo;
    model(3'd1, 32'd5, 32'd6, dz);
    op = 3'd1; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clock); #1;
    n = 0;
    while (!done && n < 100) begin
      start = 1'b0;
      if (n == 9) begin start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd0; end
      if (n == 5) begin
        chk("hold_hi", hi, prev_hi);
        chk("hold_lo", lo, prev_lo);
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    chk("ign_lat", n, 33);
    chk("ign_done", done, 1);
    chk("ign_dbz", div_by_zero, 0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd30);
    @(posedge clock); #1;
    chk("ign_after_busy", busy, 0);
    chk("ign_after_done", done, 0);

    // Reset aborts an operation mid-flight.
    op = 3'd1; a = 32'd1234; b = 32'd4321; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    chk("abort_busy_pre", busy, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    pulses = 0;
    repeat (40) begin
      if (done) pulses++;
      @(posedge clock); #1;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
